drive_supervisor: RTL and testbench

- Parametrised, multi-motor command conditioner between channels_decoder outputs and K_NMOT motor_control_top instances.
- Adds per-motor slew-rate ramping, safe reverse sequencing (ramp to zero before the direction flip), a command-loss watchdog and a latched fault state.
- Replaces the direct fan-out of one power/brake/reverse command to two hard-wired motors.

---
 rtl/drive_supervisor_pkg.sv | 17 +
 rtl/drive_ramp.sv | 58 +++++
 rtl/drive_supervisor.sv | 173 +++++++++++++++++
 tb/tb_drive_supervisor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_supervisor_pkg.sv
// Shared types for the drive supervisor: FSM state encoding and a small state helper.
package drive_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_STOPPED   = 3'd0,
    ST_RUN       = 3'd1,
    ST_REVERSING = 3'd2,
    ST_BRAKE     = 3'd3,
    ST_FAULT     = 3'd4
  } drive_state_t;

  // States in which the motors may carry a non-zero command.
  function automatic logic is_motion(drive_state_t s);
    return (s == ST_RUN) || (s == ST_REVERSING);
  endfunction

endpackage

// File: rtl/drive_ramp.sv
// Per-motor slew limiter: moves the registered command toward target by at most
// step per tick, clamped at target so it never wraps; step==0 bypasses the ramp.
module drive_ramp #(
  parameter int K_PWMRES  = 10,
  parameter int K_RAMPRES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 zero,
  input  logic [K_PWMRES-1:0]  target,
  input  logic [K_RAMPRES-1:0] step,
  output logic [K_PWMRES-1:0]  pwm,
  output logic                 at_zero
);

  localparam int W = K_PWMRES + 1;

  logic [W-1:0]        cur;
  logic [W-1:0]        tgt;
  logic [W-1:0]        stp;
  logic [W-1:0]        up;
  logic [W-1:0]        dn;
  logic [K_PWMRES-1:0] nxt;

  assign cur = {1'b0, pwm};
  assign tgt = {1'b0, target};
  assign stp = W'(step);
  assign up  = cur + stp;
  assign dn  = cur - stp;

  // dn[W-1] is the borrow when the step exceeds the current value.
  always_comb begin
    // NOTE: default first so every path assigns nxt and no latch is inferred.
    nxt = pwm;
    if (tgt > cur) begin
      nxt = (up >= tgt) ? target : up[K_PWMRES-1:0];
    end else if (tgt < cur) begin
      nxt = (dn[W-1] || (dn <= tgt)) ? target : dn[K_PWMRES-1:0];
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= '0;
    end else if (zero) begin
      pwm <= '0;
    end else if (step == '0) begin
      pwm <= target;
    end else if (tick) begin
      pwm <= nxt;
    end
  end

  assign at_zero = (pwm == '0);

endmodule

// File: rtl/drive_supervisor.sv
// Multi-motor command conditioner: slew ramping, safe reverse, watchdog and latched fault.
// Define DRIVE_SUPERVISOR_SOFT_BRAKE_EN to ramp motors to zero before asserting brake.
module drive_supervisor
  import drive_supervisor_pkg::*;
#(
  parameter int K_NMOT    = 2,
  parameter int K_PWMRES  = 10,
  parameter int K_RAMPRES = 8,
  parameter int K_WDRES   = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_tick,
  input  logic                         i_cmd_valid,
  input  logic [K_PWMRES-1:0]          i_cmd_power,
  input  logic                         i_cmd_rev,
  input  logic                         i_cmd_brake,
  input  logic [K_NMOT-1:0]            i_param_en,
  input  logic [K_RAMPRES-1:0]         i_param_ramp_step,
  input  logic [K_WDRES-1:0]           i_param_wd_thr,
  input  logic [K_NMOT-1:0]            i_fault,
  input  logic                         i_fault_clr,
  output logic [K_NMOT*K_PWMRES-1:0]   o_pwm_command,
  output logic [K_NMOT-1:0]            o_reverse,
  output logic [K_NMOT-1:0]            o_brake,
  output logic [2:0]                   o_state,
  output logic                         o_wd_expired
);

  drive_state_t        state;
  logic [K_WDRES-1:0]  wd_cnt;
  logic [K_WDRES-1:0]  wd_cnt_nxt;
  logic                fault_any;
  logic                wd_trip;
  logic                wd_exp_nxt;
  logic                dir_mismatch;
  logic                brake_path;
  logic                hard_zero;
  logic                soft_zero;
  logic                all_zero;
  logic [K_NMOT-1:0]   brake_mask;
  logic [K_NMOT-1:0]   at_zero;
  logic [K_PWMRES-1:0] target;

  assign fault_any    = |(i_fault & i_param_en);
  assign dir_mismatch = (i_cmd_rev != o_reverse[0]);
  assign all_zero     = &(at_zero | ~i_param_en);

  // A fresh command wins over a simultaneous tick; the count saturates.
  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if (i_cmd_valid) begin
      wd_cnt_nxt = '0;
    end else if (i_tick && (wd_cnt != '1)) begin
      wd_cnt_nxt = wd_cnt + 1'b1;
    end
  end

  assign wd_trip    = (i_param_wd_thr != '0) && (wd_cnt_nxt == i_param_wd_thr);
  assign wd_exp_nxt = !i_cmd_valid && (wd_trip || o_wd_expired);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_cnt       <= '0;
      o_wd_expired <= 1'b0;
    end else begin
      wd_cnt       <= wd_cnt_nxt;
      o_wd_expired <= wd_exp_nxt;
    end
  end

  // Evaluated from the current state so the ramps zero on the same edge the FSM enters BRAKE.
  assign brake_path = (state != ST_FAULT) &&
                      (wd_exp_nxt || (state == ST_BRAKE) || (is_motion(state) && i_cmd_brake));

`ifdef DRIVE_SUPERVISOR_SOFT_BRAKE_EN
  assign hard_zero  = fault_any || (state == ST_FAULT) || (state == ST_STOPPED);
  assign soft_zero  = brake_path;
  assign brake_mask = all_zero ? '1 : ~i_param_en;
`else
  assign hard_zero  = fault_any || (state == ST_FAULT) || (state == ST_STOPPED) || brake_path;
  assign soft_zero  = 1'b0;
  assign brake_mask = '1;
`endif

  // A pending direction change always ramps toward zero before the flip.
  assign target = (soft_zero || dir_mismatch) ? '0 : i_cmd_power;

  for (genvar m = 0; m < K_NMOT; m++) begin : g_motor
    drive_ramp #(
      .K_PWMRES  (K_PWMRES),
      .K_RAMPRES (K_RAMPRES)
    ) u_ramp (
      .clk     (i_clk),
      .rst     (i_rst),
      .tick    (i_tick),
      .zero    (hard_zero || !i_param_en[m]),
      .target  (target),
      .step    (i_param_ramp_step),
      .pwm     (o_pwm_command[m*K_PWMRES +: K_PWMRES]),
      .at_zero (at_zero[m])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_STOPPED;
      o_reverse <= '0;
      o_brake   <= '1;
    end else if (fault_any) begin
      state   <= ST_FAULT;
      o_brake <= '1;
    end else begin
      case (state)
        ST_STOPPED: begin
          if (wd_exp_nxt) begin
            state   <= ST_BRAKE;
            o_brake <= brake_mask;
          end else if (!i_cmd_brake && (i_cmd_power != '0)) begin
            state     <= ST_RUN;
            o_reverse <= {K_NMOT{i_cmd_rev}};
            o_brake   <= ~i_param_en;
          end else begin
            o_brake <= '1;
          end
        end
        ST_RUN: begin
          if (wd_exp_nxt || i_cmd_brake) begin
            state   <= ST_BRAKE;
            o_brake <= brake_mask;
          end else begin
            if (dir_mismatch) state <= ST_REVERSING;
            o_brake <= ~i_param_en;
          end
        end
        ST_REVERSING: begin
          if (wd_exp_nxt || i_cmd_brake) begin
            state   <= ST_BRAKE;
            o_brake <= brake_mask;
          end else if (!dir_mismatch) begin
            state   <= ST_RUN;
            o_brake <= ~i_param_en;
          end else if (all_zero) begin
            o_reverse <= ~o_reverse;
            state     <= (i_cmd_power != '0) ? ST_RUN : ST_STOPPED;
            o_brake   <= (i_cmd_power != '0) ? ~i_param_en : '1;
          end else begin
            o_brake <= ~i_param_en;
          end
        end
        ST_BRAKE: begin
          if (!i_cmd_brake && !wd_exp_nxt) begin
            state   <= ST_STOPPED;
            o_brake <= '1;
          end else begin
            o_brake <= brake_mask;
          end
        end
        ST_FAULT: begin
          if (i_fault_clr) state <= ST_STOPPED;
          o_brake <= '1;
        end
        default: begin
          state   <= ST_STOPPED;
          o_brake <= '1;
        end
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_drive_supervisor.sv
// Directed bench for drive_supervisor: a per-cycle vector table plus hand-written
// sequences for ramp-up, enable masking, watchdog and asynchronous reset.
module tb_drive_supervisor;

  localparam int NM = 2;
  localparam int PW = 10;
  localparam int RR = 8;
  localparam int WR = 16;

  localparam logic [2:0] S_STOP = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_REV  = 3'd2;
  localparam logic [2:0] S_BRK  = 3'd3;
  localparam logic [2:0] S_FLT  = 3'd4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tick = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [PW-1:0]    cmd_power = '0;
  logic             cmd_rev = 1'b0;
  logic             cmd_brake = 1'b0;
  logic [NM-1:0]    param_en = '1;
  logic [RR-1:0]    ramp_step = '0;
  logic [WR-1:0]    wd_thr = '0;
  logic [NM-1:0]    fault = '0;
  logic             fault_clr = 1'b0;
  logic [NM*PW-1:0] pwm_command;
  logic [NM-1:0]    reverse;
  logic [NM-1:0]    brake;
  logic [2:0]       state;
  logic             wd_expired;
  logic [PW-1:0]    pwm0;
  logic [PW-1:0]    pwm1;

  assign pwm0 = pwm_command[PW-1:0];
  assign pwm1 = pwm_command[2*PW-1:PW];

  drive_supervisor #(
    .K_NMOT    (NM),
    .K_PWMRES  (PW),
    .K_RAMPRES (RR),
    .K_WDRES   (WR)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_tick            (tick),
    .i_cmd_valid       (cmd_valid),
    .i_cmd_power       (cmd_power),
    .i_cmd_rev         (cmd_rev),
    .i_cmd_brake       (cmd_brake),
    .i_param_en        (param_en),
    .i_param_ramp_step (ramp_step),
    .i_param_wd_thr    (wd_thr),
    .i_fault           (fault),
    .i_fault_clr       (fault_clr),
    .o_pwm_command     (pwm_command),
    .o_reverse         (reverse),
    .o_brake           (brake),
    .o_state           (state),
    .o_wd_expired      (wd_expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          tick;
    logic [PW-1:0] power;
    logic          rev;
    logic          brk;
    logic [RR-1:0] step;
    logic [NM-1:0] fault;
    logic          clr;
    logic [PW-1:0] exp_pwm;
    logic [NM-1:0] exp_rev;
    logic [NM-1:0] exp_brake;
    logic [2:0]    exp_state;
  } vec_t;

  vec_t tbl[24];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(int t, int p, int r, int b, int s, int f, int c,
                              int ep, int er, int eb, int es);
    vec_t v;
    v.tick      = t[0];
    v.power     = p[PW-1:0];
    v.rev       = r[0];
    v.brk       = b[0];
    v.step      = s[RR-1:0];
    v.fault     = f[NM-1:0];
    v.clr       = c[0];
    v.exp_pwm   = ep[PW-1:0];
    v.exp_rev   = er[NM-1:0];
    v.exp_brake = eb[NM-1:0];
    v.exp_state = es[2:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                           input logic [NM-1:0] rv, input logic [NM-1:0] bk, input logic [2:0] st);
    check({name, ".pwm0"},  32'(pwm0),    32'(p0));
    check({name, ".pwm1"},  32'(pwm1),    32'(p1));
    check({name, ".rev"},   32'(reverse), 32'(rv));
    check({name, ".brake"}, 32'(brake),   32'(bk));
    check({name, ".state"}, 32'(state),   32'(st));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_cycle();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  initial begin
    // reverse from 600 at step 200, glitch back, brake, bypass, fault latch and clear
    tbl[0]  = mk(1, 600, 1, 0, 200, 0, 0,  400, 0, 0, S_REV);
    tbl[1]  = mk(1, 600, 1, 0, 200, 0, 0,  200, 0, 0, S_REV);
    tbl[2]  = mk(1, 600, 1, 0, 200, 0, 0,    0, 0, 0, S_REV);
    tbl[3]  = mk(0, 600, 1, 0, 200, 0, 0,    0, 3, 0, S_RUN);
    tbl[4]  = mk(1, 600, 1, 0, 200, 0, 0,  200, 3, 0, S_RUN);
    tbl[5]  = mk(1, 600, 1, 0, 200, 0, 0,  400, 3, 0, S_RUN);
    tbl[6]  = mk(1, 600, 1, 0, 200, 0, 0,  600, 3, 0, S_RUN);
    tbl[7]  = mk(0, 600, 1, 0, 200, 0, 0,  600, 3, 0, S_RUN);
    tbl[8]  = mk(1, 600, 0, 0, 200, 0, 0,  400, 3, 0, S_REV);
    tbl[9]  = mk(1, 600, 0, 0, 200, 0, 0,  200, 3, 0, S_REV);
    tbl[10] = mk(0, 600, 1, 0, 200, 0, 0,  200, 3, 0, S_RUN);
    tbl[11] = mk(1, 600, 1, 0, 200, 0, 0,  400, 3, 0, S_RUN);
    tbl[12] = mk(0, 600, 1, 1, 200, 0, 0,    0, 3, 3, S_BRK);
    tbl[13] = mk(1, 600, 1, 1, 200, 0, 0,    0, 3, 3, S_BRK);
    tbl[14] = mk(0, 600, 1, 0, 200, 0, 0,    0, 3, 3, S_STOP);
    tbl[15] = mk(0, 600, 0, 0, 200, 0, 0,    0, 0, 0, S_RUN);
    tbl[16] = mk(0, 300, 0, 0,   0, 0, 0,  300, 0, 0, S_RUN);
    tbl[17] = mk(0,  50, 0, 0,   0, 0, 0,   50, 0, 0, S_RUN);
    tbl[18] = mk(0, 1023, 0, 0,  0, 0, 0, 1023, 0, 0, S_RUN);
    tbl[19] = mk(0, 1023, 0, 0,  0, 2, 0,    0, 0, 3, S_FLT);
    tbl[20] = mk(0, 1023, 0, 0,  0, 2, 1,    0, 0, 3, S_FLT);
    tbl[21] = mk(0, 1023, 0, 0,  0, 0, 0,    0, 0, 3, S_FLT);
    tbl[22] = mk(0,   0, 0, 0,   0, 0, 1,    0, 0, 3, S_STOP);
    tbl[23] = mk(0,   0, 0, 0,   0, 0, 0,    0, 0, 3, S_STOP);

    // reset state, asserted between edges
    cmd_power = 10'd1000;
    ramp_step = 8'd100;
    #1 rst = 1'b1;
    #3;
    check_all("reset", 0, 0, 2'b00, 2'b11, S_STOP);
    check("reset.wd", 32'(wd_expired), 0);
    @(negedge clk);
    rst = 1'b0;

    // ramp up 0 -> 1000 in steps of 100, one tick every 10 cycles
    cycle();
    check_all("run_entry", 0, 0, 2'b00, 2'b00, S_RUN);
    for (int k = 1; k <= 10; k++) begin
      repeat (9) cycle();
      tick_cycle();
      check($sformatf("ramp_up%0d.pwm0", k), 32'(pwm0), 32'(100 * k));
      check($sformatf("ramp_up%0d.pwm1", k), 32'(pwm1), 32'(100 * k));
    end
    tick_cycle();
    check("no_overshoot", 32'(pwm0), 1000);
    cmd_power = 10'd1023;
    ramp_step = 8'd255;
    tick_cycle();
    check("clamp_top", 32'(pwm0), 1023);
    cmd_power = 10'd600;
    ramp_step = 8'd200;
    tick_cycle();
    check("ramp_down1", 32'(pwm0), 823);
    tick_cycle();
    check("ramp_down2", 32'(pwm0), 623);
    tick_cycle();
    check_all("ramp_down3", 600, 600, 2'b00, 2'b00, S_RUN);

    for (int i = 0; i < 24; i++) begin
      tick      = tbl[i].tick;
      cmd_power = tbl[i].power;
      cmd_rev   = tbl[i].rev;
      cmd_brake = tbl[i].brk;
      ramp_step = tbl[i].step;
      fault     = tbl[i].fault;
      fault_clr = tbl[i].clr;
      cycle();
      check_all($sformatf("vec%0d", i), tbl[i].exp_pwm, tbl[i].exp_pwm,
                tbl[i].exp_rev, tbl[i].exp_brake, tbl[i].exp_state);
    end
    tick      = 1'b0;
    fault_clr = 1'b0;

    // enable mask: motor1 disabled stays at zero with brake, reverse does not wait on it
    param_en  = 2'b01;
    cmd_power = 10'd500;
    ramp_step = 8'd100;
    cmd_rev   = 1'b0;
    cycle();
    check_all("en_entry", 0, 0, 2'b00, 2'b10, S_RUN);
    tick_cycle();
    check_all("en_t1", 100, 0, 2'b00, 2'b10, S_RUN);
    tick_cycle();
    check_all("en_t2", 200, 0, 2'b00, 2'b10, S_RUN);
    fault = 2'b10;
    cycle();
    check("en_masked_fault", 32'(state), 32'(S_RUN));
    fault   = 2'b00;
    cmd_rev = 1'b1;
    tick_cycle();
    check_all("en_rev1", 100, 0, 2'b00, 2'b10, S_REV);
    tick_cycle();
    check_all("en_rev2", 0, 0, 2'b00, 2'b10, S_REV);
    cycle();
    check_all("en_flip", 0, 0, 2'b11, 2'b10, S_RUN);

    // watchdog: valid beats a simultaneous tick, then the 5th tick expires
    param_en  = 2'b11;
    ramp_step = 8'd0;
    cmd_power = 10'd300;
    wd_thr    = 16'd5;
    cmd_valid = 1'b1;
    tick      = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    tick      = 1'b0;
    check_all("wd_start", 300, 300, 2'b11, 2'b00, S_RUN);
    for (int k = 1; k <= 5; k++) begin
      repeat (2) cycle();
      tick_cycle();
      if (k == 4) begin
        check("wd_tick4.flag", 32'(wd_expired), 0);
        check("wd_tick4.state", 32'(state), 32'(S_RUN));
      end
    end
    check("wd_tick5.flag", 32'(wd_expired), 1);
    check_all("wd_tick5", 0, 0, 2'b11, 2'b11, S_BRK);
    cycle();
    check("wd_hold_brake", 32'(state), 32'(S_BRK));
    cmd_power = 10'd0;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    check("wd_clear.flag", 32'(wd_expired), 0);
    check("wd_clear.state", 32'(state), 32'(S_STOP));
    wd_thr = 16'd0;

    // asynchronous reset mid-ramp
    cmd_power = 10'd800;
    ramp_step = 8'd100;
    cmd_rev   = 1'b0;
    cycle();
    tick_cycle();
    tick_cycle();
    check_all("pre_reset", 200, 200, 2'b00, 2'b00, S_RUN);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 2'b00, 2'b11, S_STOP);
    check("async_reset.wd", 32'(wd_expired), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
